// File: rtl/video_source_scheduler.sv
// Frame-synchronous two-source video scheduler: muxes the pattern generator or the
// live SIFT stream onto the encoder path, switching sources only at frame boundaries.
module video_source_scheduler #(
   parameter int          H_ACTIVE     = 640,
   parameter int          V_ACTIVE     = 480,
   parameter int          UNDERRUN_MAX = 16,
   parameter int          HOLD_FRAMES  = 4,
   parameter logic [23:0] FILL_COLOR   = 24'h000000
) (
   input  logic        Clock,
   input  logic        Reset,
   input  logic        DownReady,
   output logic [23:0] Video,
   input  logic [23:0] PatVideo,
   output logic        PatReady,
   input  logic [23:0] LiveVideo,
   input  logic        LiveValid,
   output logic        LiveReady,
   input  logic        SelLive,
   input  logic        ClearStatus,
   output logic        ActiveSrc,
   output logic        FrameStart,
   output logic        Underrun,
   output logic [7:0]  FallbackCount,
   output logic [1:0]  DebugState
);

   localparam int XW = $clog2(H_ACTIVE);
   localparam int YW = (V_ACTIVE > 1) ? $clog2(V_ACTIVE) : 1;
   localparam int HW = $clog2(HOLD_FRAMES + 1);
   localparam logic [XW-1:0] X_LAST    = XW'(H_ACTIVE - 1);
   localparam logic [YW-1:0] Y_LAST    = YW'(V_ACTIVE - 1);
   localparam logic [HW-1:0] HOLD_LOAD = HW'(HOLD_FRAMES);

   typedef enum logic [1:0] {
      S_PAT  = 2'd0,
      S_LIVE = 2'd1,
      S_HOLD = 2'd2
   } state_t;

   state_t        state_q, state_d;
   logic [XW-1:0] x_q;
   logic [YW-1:0] y_q;
   logic [7:0]    under_q, under_next;
   logic [HW-1:0] hold_q;
   logic          underrun_q;
   logic [7:0]    fallback_q;
   logic          active_q;
   logic          frame_end, under_beat, fallback;

   // Handshake: the encoder takes Video on every cycle DownReady is high. Only the
   // active source sees a ready; the live source is consumed only when LiveValid is
   // also high, and a missing live pixel is replaced by FILL_COLOR without stalling.
   assign frame_end  = DownReady && (x_q == X_LAST) && (y_q == Y_LAST);
   assign under_beat = (state_q == S_LIVE) && DownReady && !LiveValid;
   assign under_next = (under_beat && under_q != 8'hFF) ? under_q + 8'd1 : under_q;
   assign fallback   = (state_q == S_LIVE) && (int'(under_next) > UNDERRUN_MAX);

   // State register
   always_ff @(posedge Clock) begin
      if (Reset) begin
         state_q  <= S_PAT;
         active_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         active_q <= (state_d == S_LIVE);
      end
   end

   // Next-state logic; decisions are taken only in the last pixel of a frame
   always_comb begin
      state_d = state_q;
      if (frame_end) begin
         case (state_q)
            S_PAT:   if (SelLive) state_d = S_LIVE;
            S_LIVE: begin
               if (fallback)      state_d = S_HOLD;
               else if (!SelLive) state_d = S_PAT;
            end
            S_HOLD:  if (hold_q <= HW'(1)) state_d = S_PAT;
            default: state_d = S_PAT;
         endcase
      end
   end

   // Output logic
   always_comb begin
      PatReady   = DownReady && (state_q != S_LIVE);
      LiveReady  = DownReady && (state_q == S_LIVE) && LiveValid;
      Video      = PatVideo;
      if (state_q == S_LIVE) Video = LiveValid ? LiveVideo : FILL_COLOR;
      ActiveSrc  = active_q;
      FrameStart = (x_q == '0) && (y_q == '0);
      DebugState = state_q;
   end

   always_ff @(posedge Clock) begin
      if (Reset) begin
         x_q <= '0;
         y_q <= '0;
      end else if (DownReady) begin
         if (x_q == X_LAST) begin
            x_q <= '0;
            y_q <= (y_q == Y_LAST) ? '0 : y_q + YW'(1);
         end else begin
            x_q <= x_q + XW'(1);
         end
      end
   end

   // Per-frame underrun tally, lockout timer and status
   always_ff @(posedge Clock) begin
      if (Reset) begin
         under_q    <= 8'd0;
         hold_q     <= '0;
         underrun_q <= 1'b0;
         fallback_q <= 8'd0;
      end else begin
         under_q <= frame_end ? 8'd0 : under_next;
         if (under_beat)       underrun_q <= 1'b1;
         else if (ClearStatus) underrun_q <= 1'b0;
         if (frame_end && fallback) begin
            hold_q <= HOLD_LOAD;
            if (fallback_q != 8'hFF) fallback_q <= fallback_q + 8'd1;
         end else if (frame_end && state_q == S_HOLD && hold_q != '0) begin
            hold_q <= hold_q - HW'(1);
         end
      end
   end

   assign Underrun      = underrun_q;
   assign FallbackCount = fallback_q;

endmodule

// File: tb/tb_video_source_scheduler.sv
// Bench for video_source_scheduler with a 4x2 frame, underrun limit 2, lockout 2 frames.
module tb_video_source_scheduler;

   localparam int H  = 4;
   localparam int V  = 2;
   localparam int UM = 2;
   localparam int HF = 2;

   logic        Clock = 1'b0;
   logic        Reset = 1'b1;
   logic        DownReady = 1'b0;
   logic        SelLive = 1'b0;
   logic        LiveValid = 1'b0;
   logic        ClearStatus = 1'b0;
   logic [23:0] PatVideo = 24'h0;
   logic [23:0] LiveVideo = 24'h0;
   logic [23:0] Video;
   logic        PatReady, LiveReady, ActiveSrc, FrameStart, Underrun;
   logic [7:0]  FallbackCount;
   logic [1:0]  DebugState;

   video_source_scheduler #(
      .H_ACTIVE(H), .V_ACTIVE(V), .UNDERRUN_MAX(UM), .HOLD_FRAMES(HF),
      .FILL_COLOR(24'h000000)
   ) dut (
      .Clock(Clock), .Reset(Reset), .DownReady(DownReady), .Video(Video),
      .PatVideo(PatVideo), .PatReady(PatReady), .LiveVideo(LiveVideo),
      .LiveValid(LiveValid), .LiveReady(LiveReady), .SelLive(SelLive),
      .ClearStatus(ClearStatus), .ActiveSrc(ActiveSrc), .FrameStart(FrameStart),
      .Underrun(Underrun), .FallbackCount(FallbackCount), .DebugState(DebugState)
   );

   always #5 Clock = ~Clock;

   int errors = 0;
   int checks = 0;
   logic [23:0] exp_q[$];

   // Reference model state: 0 pattern, 1 live, 2 hold
   int m_state = 0, mx = 0, my = 0, m_ucnt = 0, m_hold = 0, m_fb = 0;
   bit m_under = 0, m_active = 0;

   logic [23:0] obs_video;
   logic        obs_pr, obs_lr, obs_fs;

   task automatic beat(input bit rst, input bit dr, input bit sel, input bit lv,
                       input bit clr, input logic [23:0] lvid);
      logic [23:0] got;
      bit epr, elr, efs, ub, fe;
      @(negedge Clock);
      Reset = rst; DownReady = dr; SelLive = sel; LiveValid = lv;
      ClearStatus = clr; LiveVideo = lvid; PatVideo = 24'($urandom());
      exp_q.push_back((m_state == 1) ? (lv ? lvid : 24'h000000) : PatVideo);
      epr = dr && (m_state != 1);
      elr = dr && (m_state == 1) && lv;
      efs = (mx == 0) && (my == 0);
      #1;
      obs_video = Video; obs_pr = PatReady; obs_lr = LiveReady; obs_fs = FrameStart;
      got = exp_q.pop_front();
      checks++; if (Video !== got) begin errors++; $display("FAIL video: got %h exp %h", Video, got); end
      checks++; if (PatReady !== epr) begin errors++; $display("FAIL patready: got %b exp %b", PatReady, epr); end
      checks++; if (LiveReady !== elr) begin errors++; $display("FAIL liveready: got %b exp %b", LiveReady, elr); end
      checks++; if (FrameStart !== efs) begin errors++; $display("FAIL framestart: got %b exp %b", FrameStart, efs); end
      checks++; if (DebugState !== 2'(m_state)) begin errors++; $display("FAIL state: got %0d exp %0d", DebugState, m_state); end
      @(posedge Clock);
      if (rst) begin
         m_state = 0; mx = 0; my = 0; m_ucnt = 0; m_hold = 0; m_fb = 0; m_under = 0;
      end else begin
         ub = (m_state == 1) && dr && !lv;
         fe = dr && (mx == H - 1) && (my == V - 1);
         if (ub) begin
            if (m_ucnt < 255) m_ucnt++;
            m_under = 1;
         end else if (clr) m_under = 0;
         if (fe) begin
            if (m_state == 0) begin
               if (sel) m_state = 1;
            end else if (m_state == 1) begin
               if (m_ucnt > UM) begin
                  m_state = 2; m_hold = HF;
                  if (m_fb < 255) m_fb++;
               end else if (!sel) m_state = 0;
            end else begin
               m_hold--;
               if (m_hold == 0) m_state = 0;
            end
            m_ucnt = 0;
         end
         if (dr) begin
            if (mx == H - 1) begin
               mx = 0; my = (my == V - 1) ? 0 : my + 1;
            end else mx++;
         end
      end
      m_active = (m_state == 1);
      #1;
      checks++; if (ActiveSrc !== m_active) begin errors++; $display("FAIL activesrc: got %b exp %b", ActiveSrc, m_active); end
      checks++; if (Underrun !== m_under) begin errors++; $display("FAIL underrun: got %b exp %b", Underrun, m_under); end
      checks++; if (FallbackCount !== 8'(m_fb)) begin errors++; $display("FAIL fallbackcount: got %0d exp %0d", FallbackCount, m_fb); end
   endtask

   task automatic test_reset();
      beat(1, 1, 1, 0, 0, 24'h123456);
      beat(1, 0, 0, 0, 0, 24'h0);
      checks++; if (ActiveSrc !== 1'b0) begin errors++; $display("FAIL reset_active: got %b exp 0", ActiveSrc); end
      checks++; if (FrameStart !== 1'b1) begin errors++; $display("FAIL reset_framestart: got %b exp 1", FrameStart); end
      checks++; if (Underrun !== 1'b0) begin errors++; $display("FAIL reset_underrun: got %b exp 0", Underrun); end
      checks++; if (FallbackCount !== 8'd0) begin errors++; $display("FAIL reset_fallback: got %0d exp 0", FallbackCount); end
      checks++; if (DebugState !== 2'd0) begin errors++; $display("FAIL reset_state: got %0d exp 0", DebugState); end
   endtask

   task automatic test_pattern();
      int pulses = 0;
      for (int i = 0; i < 8; i++) begin
         beat(0, 1, 0, 0, 0, 24'h0);
         if (obs_pr) pulses++;
         if (i == 0) begin
            checks++; if (obs_fs !== 1'b1) begin errors++; $display("FAIL pat_fs0: got %b exp 1", obs_fs); end
         end
      end
      checks++; if (pulses != 8) begin errors++; $display("FAIL pat_pulses: got %0d exp 8", pulses); end
      checks++; if (FrameStart !== 1'b1) begin errors++; $display("FAIL pat_fs8: got %b exp 1", FrameStart); end
      checks++; if (ActiveSrc !== 1'b0) begin errors++; $display("FAIL pat_active: got %b exp 0", ActiveSrc); end
   endtask

   task automatic test_sel_live();
      for (int i = 0; i < 8; i++) begin
         beat(0, 1, i >= 3, 0, 0, 24'h0);
         if (i == 6) begin
            checks++; if (ActiveSrc !== 1'b0) begin errors++; $display("FAIL sel_midframe: got %b exp 0", ActiveSrc); end
         end
      end
      checks++; if (ActiveSrc !== 1'b1) begin errors++; $display("FAIL sel_active: got %b exp 1", ActiveSrc); end
      for (int i = 0; i < 9; i++) begin
         beat(0, i != 4, 1, 1, 0, 24'h1ABC9C);
         checks++; if (obs_video !== 24'h1ABC9C) begin errors++; $display("FAIL live_video: got %h exp 1abc9c", obs_video); end
         checks++; if (obs_lr !== (i != 4)) begin errors++; $display("FAIL live_ready: got %b exp %b", obs_lr, i != 4); end
      end
   endtask

   task automatic test_underrun();
      for (int i = 0; i < 8; i++) begin
         beat(0, 1, 1, !(i == 2 || i == 5), 0, 24'h1ABC00 + 24'(i));
         if (i == 2 || i == 5) begin
            checks++; if (obs_video !== 24'h000000) begin errors++; $display("FAIL ur_fill: got %h exp 000000", obs_video); end
            checks++; if (obs_lr !== 1'b0) begin errors++; $display("FAIL ur_ready: got %b exp 0", obs_lr); end
         end
      end
      checks++; if (Underrun !== 1'b1) begin errors++; $display("FAIL ur_sticky: got %b exp 1", Underrun); end
      checks++; if (FrameStart !== 1'b1) begin errors++; $display("FAIL ur_wrap: got %b exp 1", FrameStart); end
      checks++; if (ActiveSrc !== 1'b1) begin errors++; $display("FAIL ur_stay_live: got %b exp 1", ActiveSrc); end
      beat(0, 1, 1, 0, 1, 24'h0);
      checks++; if (Underrun !== 1'b1) begin errors++; $display("FAIL ur_set_wins: got %b exp 1", Underrun); end
      beat(0, 1, 1, 1, 1, 24'h0A0B0C);
      checks++; if (Underrun !== 1'b0) begin errors++; $display("FAIL ur_clear: got %b exp 0", Underrun); end
      for (int i = 2; i < 8; i++) beat(0, 1, 1, 1, 0, 24'($urandom()));
      checks++; if (ActiveSrc !== 1'b1) begin errors++; $display("FAIL ur_one_beat_live: got %b exp 1", ActiveSrc); end
   endtask

   task automatic test_fallback();
      // Third underrun lands in the FrameEnd beat itself
      for (int i = 0; i < 8; i++) beat(0, 1, 1, !(i == 1 || i == 3 || i == 7), 0, 24'h00FF00);
      checks++; if (ActiveSrc !== 1'b0) begin errors++; $display("FAIL fb_active: got %b exp 0", ActiveSrc); end
      checks++; if (FallbackCount !== 8'd1) begin errors++; $display("FAIL fb_count: got %0d exp 1", FallbackCount); end
      checks++; if (DebugState !== 2'd2) begin errors++; $display("FAIL fb_hold: got %0d exp 2", DebugState); end
      for (int f = 0; f < 3; f++) begin
         for (int i = 0; i < 8; i++) begin
            beat(0, 1, 1, 1, 0, 24'h55AA00);
            checks++; if (obs_pr !== 1'b1) begin errors++; $display("FAIL fb_pattern: frame %0d got %b exp 1", f, obs_pr); end
         end
         checks++; if (ActiveSrc !== (f == 2)) begin errors++; $display("FAIL fb_resume: frame %0d got %b exp %b", f, ActiveSrc, f == 2); end
      end
      beat(0, 1, 1, 1, 0, 24'h55AA00);
      checks++; if (obs_video !== 24'h55AA00) begin errors++; $display("FAIL fb_live_video: got %h exp 55aa00", obs_video); end
   endtask

   task automatic test_reset_mid();
      for (int i = 1; i < 5; i++) beat(0, 1, 1, i != 2, 0, 24'h777777);
      beat(1, 1, 1, 1, 0, 24'h777777);
      checks++; if (ActiveSrc !== 1'b0) begin errors++; $display("FAIL rm_active: got %b exp 0", ActiveSrc); end
      checks++; if (FrameStart !== 1'b1) begin errors++; $display("FAIL rm_framestart: got %b exp 1", FrameStart); end
      checks++; if (Underrun !== 1'b0) begin errors++; $display("FAIL rm_underrun: got %b exp 0", Underrun); end
      checks++; if (FallbackCount !== 8'd0) begin errors++; $display("FAIL rm_fallback: got %0d exp 0", FallbackCount); end
      beat(0, 1, 0, 1, 0, 24'h777777);
      checks++; if (obs_pr !== 1'b1) begin errors++; $display("FAIL rm_patready: got %b exp 1", obs_pr); end
      checks++; if (obs_fs !== 1'b1) begin errors++; $display("FAIL rm_first_fs: got %b exp 1", obs_fs); end
      checks++; if (obs_video !== PatVideo) begin errors++; $display("FAIL rm_first_pixel: got %h exp %h", obs_video, PatVideo); end
   endtask

   task automatic test_toggle();
      beat(1, 0, 0, 0, 0, 24'h0);
      for (int c = 0; c < 16; c++) begin
         beat(0, (c % 2) == 0, 1, 0, 0, 24'h0);
         if (c % 2 == 1) begin
            checks++; if (obs_pr !== 1'b0) begin errors++; $display("FAIL tg_idle_ready: cycle %0d got %b exp 0", c, obs_pr); end
         end
         if (c == 13) begin
            checks++; if (ActiveSrc !== 1'b0) begin errors++; $display("FAIL tg_before_end: got %b exp 0", ActiveSrc); end
         end
         if (c == 14) begin
            checks++; if (ActiveSrc !== 1'b1) begin errors++; $display("FAIL tg_frame_end: got %b exp 1", ActiveSrc); end
         end
      end
   endtask

   initial begin
      test_reset();
      test_pattern();
      test_sel_live();
      test_underrun();
      test_fallback();
      test_reset_mid();
      test_toggle();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
